mat_mul_acc: RTL and testbench

- Pipelined N×N signed matrix arithmetic unit. Successor to the single-shot multiply/add unit.
- Adds subtract and element-wise (Hadamard) modes.
- Uses one uniform latency for every mode, so back-to-back mixed-mode beats never collide.
- Has an N×N accumulator for tiled K-dimension products, so matrices larger than N are built from a sequence of tile beats.
- Sits between the operand fetch stage and the writeback buffer of the SIMD datapath.

---
 rtl/mat_mul_acc.sv | 162 ++++++++++++++++
 tb/tb_mat_mul_acc.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mul_acc.sv
// mat_mul_acc: pipelined N x N signed matrix unit (MUL / ADD / SUB / EMUL)
// with an N x N accumulator for tiled K-dimension products.
// Pipeline: operand capture -> term stage -> clog2(N) adder-tree levels ->
// accumulate/output stage. Non-MUL modes put their element value on term 0
// and zeros elsewhere, so every mode takes exactly the same path and latency.
module mat_mul_acc #(
   parameter int W_IN  = 8,
   parameter int W_OUT = 32,
   parameter int N     = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 cen,
   input  logic                                 valid_in,
   input  logic [1:0]                           mode,
   input  logic                                 acc_first,
   input  logic                                 acc_last,
   input  logic [N-1:0][N-1:0][W_IN-1:0]        matrix_1,
   input  logic [N-1:0][N-1:0][W_IN-1:0]        matrix_2,
   output logic                                 valid_out,
   output logic [N-1:0][N-1:0][W_OUT-1:0]       result
);

   localparam int LG = $clog2(N);
   // Per-element tree storage: N leaf terms followed by each level's nodes.
   localparam int NT = 2*N - 1;

   typedef enum logic [1:0] {
      MODE_MUL  = 2'd0,
      MODE_ADD  = 2'd1,
      MODE_SUB  = 2'd2,
      MODE_EMUL = 2'd3
   } mode_t;

   // Sign-extend one operand element to the result width.
   function automatic logic [W_OUT-1:0] sext(input logic [W_IN-1:0] v);
      return {{(W_OUT-W_IN){v[W_IN-1]}}, v};
   endfunction

   // Leaf term k of element (i,j): row/col elements feed the dot product,
   // a_el/b_el are element (i,j) and only the lead term (k==0) carries them.
   function automatic logic [W_OUT-1:0] term_val(
      input logic [1:0]      md,
      input logic [W_IN-1:0] row_el,
      input logic [W_IN-1:0] col_el,
      input logic [W_IN-1:0] a_el,
      input logic [W_IN-1:0] b_el,
      input logic            lead
   );
      logic [W_OUT-1:0] v;
      v = '0;
      case (md)
         MODE_MUL:  v = sext(row_el) * sext(col_el);
         MODE_ADD:  v = lead ? (sext(a_el) + sext(b_el)) : '0;
         MODE_SUB:  v = lead ? (sext(a_el) - sext(b_el)) : '0;
         MODE_EMUL: v = lead ? (sext(a_el) * sext(b_el)) : '0;
         default:   v = '0;
      endcase
      return v;
   endfunction

   logic [N-1:0][N-1:0][W_IN-1:0]  cap_m1_r;
   logic [N-1:0][N-1:0][W_IN-1:0]  cap_m2_r;
   logic [1:0]                     cap_mode_r;
   logic                           cap_vld_r;
   logic                           cap_first_r;
   logic                           cap_last_r;
   logic [LG:0]                    vld_r;
   logic [LG:0]                    first_r;
   logic [LG:0]                    last_r;
   logic [N-1:0][N-1:0][W_OUT-1:0] tree_out_s;
   logic [N-1:0][N-1:0][W_OUT-1:0] acc_r;
   logic [N-1:0][N-1:0][W_OUT-1:0] acc_nxt_s;
   logic                           acc_open_r;
   logic                           acc_start_s;

   // Operand capture: data registers need no reset, their valid bit gates them.
   always_ff @(posedge clk) begin
      if (cen) begin
         cap_m1_r   <= matrix_1;
         cap_m2_r   <= matrix_2;
         cap_mode_r <= mode;
      end
   end

   // Beat valid and accumulation sideband travel alongside the data stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_vld_r   <= 1'b0;
         cap_first_r <= 1'b0;
         cap_last_r  <= 1'b0;
         vld_r       <= '0;
         first_r     <= '0;
         last_r      <= '0;
      end else if (cen) begin
         cap_vld_r   <= valid_in;
         cap_first_r <= acc_first;
         cap_last_r  <= acc_last;
         vld_r       <= {vld_r[LG-1:0], cap_vld_r};
         first_r     <= {first_r[LG-1:0], cap_first_r};
         last_r      <= {last_r[LG-1:0], cap_last_r};
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         logic [NT-1:0][W_OUT-1:0] tr_r;
         logic [NT-1:0][W_OUT-1:0] tr_s;

         for (genvar gk = 0; gk < N; gk++) begin : g_term
            assign tr_s[gk] = term_val(cap_mode_r,
                                       cap_m1_r[gi][gk], cap_m2_r[gk][gj],
                                       cap_m1_r[gi][gj], cap_m2_r[gi][gj],
                                       (gk == 0));
         end

         for (genvar gl = 1; gl <= LG; gl++) begin : g_lvl
            localparam int BASE_IN  = 2*N - 2*(N >> (gl-1));
            localparam int BASE_OUT = 2*N - 2*(N >> gl);
            for (genvar gt = 0; gt < (N >> gl); gt++) begin : g_node
               assign tr_s[BASE_OUT+gt] = tr_r[BASE_IN+2*gt] + tr_r[BASE_IN+2*gt+1];
            end
         end

         // Term stage and every adder-tree level advance together.
         always_ff @(posedge clk) begin
            if (cen) begin
               tr_r <= tr_s;
            end
         end

         assign tree_out_s[gi][gj] = tr_r[NT-1];
         assign acc_nxt_s[gi][gj]  = acc_start_s ? tree_out_s[gi][gj]
                                                 : (acc_r[gi][gj] + tree_out_s[gi][gj]);
      end
   end

   // A beat with no open accumulation behind it starts a fresh one.
   assign acc_start_s = first_r[LG] | ~acc_open_r;

   // Output stage: fold each valid beat into the accumulator, publish on acc_last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r      <= '0;
         acc_open_r <= 1'b0;
         result     <= '0;
         valid_out  <= 1'b0;
      end else if (cen) begin
         if (vld_r[LG]) begin
            acc_r      <= acc_nxt_s;
            acc_open_r <= ~last_r[LG];
            valid_out  <= last_r[LG];
            if (last_r[LG]) begin
               result <= acc_nxt_s;
            end
         end else begin
            valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mat_mul_acc.sv
// Self-checking bench for mat_mul_acc: constant-matrix vector table, directed
// multi-cycle sequences (latency, tiling, stall, wrap, async reset) and a
// randomized run compared against a matrix-level reference model.
module tb_mat_mul_acc;

   localparam int N     = 4;
   localparam int W_IN  = 8;
   localparam int W_OUT = 32;
   localparam int LAT   = $clog2(N) + 2;
   localparam int WN    = 2;
   localparam int WW    = 16;
   localparam int WLAT  = $clog2(WN) + 2;

   typedef logic [N-1:0][N-1:0][W_IN-1:0]   imat_t;
   typedef logic [N-1:0][N-1:0][W_OUT-1:0]  omat_t;
   typedef logic [WN-1:0][WN-1:0][W_IN-1:0] wimat_t;
   typedef logic [WN-1:0][WN-1:0][WW-1:0]   womat_t;

   typedef struct {
      logic       v;
      logic [1:0] md;
      logic       f;
      logic       l;
      imat_t      a;
      imat_t      b;
   } beat_t;

   typedef struct {
      logic [1:0]  md;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [31:0] e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cen = 1'b1;
   logic       valid_in = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       acc_first = 1'b0;
   logic       acc_last = 1'b0;
   imat_t      matrix_1 = '0;
   imat_t      matrix_2 = '0;
   logic       valid_out;
   omat_t      result;

   logic       w_valid = 1'b0;
   logic       w_first = 1'b0;
   logic       w_last = 1'b0;
   wimat_t     w_m1 = '0;
   wimat_t     w_m2 = '0;
   logic       w_vout;
   womat_t     w_res;

   int checks = 0;
   int errors = 0;

   mat_mul_acc #(.W_IN(W_IN), .W_OUT(W_OUT), .N(N)) u_dut (
      .clk(clk), .rst(rst), .cen(cen), .valid_in(valid_in), .mode(mode),
      .acc_first(acc_first), .acc_last(acc_last),
      .matrix_1(matrix_1), .matrix_2(matrix_2),
      .valid_out(valid_out), .result(result)
   );

   mat_mul_acc #(.W_IN(W_IN), .W_OUT(WW), .N(WN)) u_wrap (
      .clk(clk), .rst(rst), .cen(cen), .valid_in(w_valid), .mode(mode),
      .acc_first(w_first), .acc_last(w_last),
      .matrix_1(w_m1), .matrix_2(w_m2),
      .valid_out(w_vout), .result(w_res)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   beat_t pq[$];
   omat_t m_acc;
   omat_t m_res;
   logic  m_open;
   logic  m_vout;

   function automatic omat_t beat_val(input beat_t bt);
      omat_t  r;
      longint s;
      int     x, y;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            s = 0;
            x = $signed(bt.a[i][j]);
            y = $signed(bt.b[i][j]);
            case (bt.md)
               2'd0: for (int k = 0; k < N; k++) s += longint'($signed(bt.a[i][k])) * longint'($signed(bt.b[k][j]));
               2'd1: s = x + y;
               2'd2: s = x - y;
               default: s = x * y;
            endcase
            r[i][j] = s[W_OUT-1:0];
         end
      end
      return r;
   endfunction

   task automatic model_clear();
      pq.delete();
      m_acc  = '0;
      m_res  = '0;
      m_open = 1'b0;
      m_vout = 1'b0;
   endtask

   task automatic model_apply(input beat_t bt);
      omat_t v;
      if (!bt.v) begin
         m_vout = 1'b0;
      end else begin
         v = beat_val(bt);
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               m_acc[i][j] = (bt.f || !m_open) ? v[i][j] : m_acc[i][j] + v[i][j];
         if (bt.l) begin
            m_res  = m_acc;
            m_vout = 1'b1;
            m_open = 1'b0;
         end else begin
            m_vout = 1'b0;
            m_open = 1'b1;
         end
      end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_mat(input string name, input omat_t act, input omat_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic imat_t fill_i(input logic [7:0] v);
      return {(N*N){v}};
   endfunction

   function automatic omat_t fill_o(input logic [31:0] v);
      return {(N*N){v}};
   endfunction

   function automatic beat_t mk(input logic v, input logic [1:0] md, input logic f,
                                input logic l, input imat_t a, input imat_t b);
      beat_t bt;
      bt.v = v; bt.md = md; bt.f = f; bt.l = l; bt.a = a; bt.b = b;
      return bt;
   endfunction

   // Drive one beat for one clock; the model sees it only on enabled edges.
   task automatic tick(input beat_t bt, input logic c);
      cen = c; valid_in = bt.v; mode = bt.md; acc_first = bt.f; acc_last = bt.l;
      matrix_1 = bt.a; matrix_2 = bt.b;
      @(posedge clk);
      #1;
      if (c) begin
         pq.push_back(bt);
         if (pq.size() > LAT) model_apply(pq.pop_front());
      end
   endtask

   vec_t  vt[7];
   beat_t bub;
   imat_t id, m2, ra, rb;
   omat_t exp_m;
   logic  c, ex;

   initial begin
      vt[0] = '{2'd1, 8'h80, 8'h80, 32'hFFFF_FF00};  // ADD -128+-128 = -256
      vt[1] = '{2'd2, 8'h05, 8'h07, 32'hFFFF_FFFE};  // SUB 5-7 = -2
      vt[2] = '{2'd3, 8'hFD, 8'h04, 32'hFFFF_FFF4};  // EMUL -3*4 = -12
      vt[3] = '{2'd0, 8'h01, 8'h01, 32'h0000_0004};  // MUL ones, N=4
      vt[4] = '{2'd0, 8'h80, 8'h80, 32'h0001_0000};  // MUL 4*16384
      vt[5] = '{2'd2, 8'h80, 8'h7F, 32'hFFFF_FF01};  // SUB -128-127 = -255
      vt[6] = '{2'd3, 8'h7F, 8'h80, 32'hFFFF_C080};  // EMUL 127*-128 = -16256

      bub = mk(1'b0, 2'd0, 1'b0, 1'b0, '0, '0);
      model_clear();

      // reset state
      #2 rst = 1'b1;
      #1;
      chk("rst_vout", int'(valid_out), 0);
      chk_mat("rst_result", result, '0);
      chk("rst_wrap_vout", int'(w_vout), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // single-shot MUL: identity * m2 = m2, valid exactly LAT edges later
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            id[i][j]    = (i == j) ? 8'd1 : 8'd0;
            m2[i][j]    = 8'(4*i + j);
            exp_m[i][j] = 32'(4*i + j);
         end
      tick(mk(1'b1, 2'd0, 1'b1, 1'b1, id, m2), 1'b1);
      for (int k = 1; k <= LAT + 1; k++) begin
         tick(bub, 1'b1);
         chk("ident_vout", int'(valid_out), int'(k == LAT));
         if (k == LAT) chk_mat("ident_result", result, exp_m);
      end

      // back-to-back mixed-mode single-shot table
      for (int k = 0; k < 7 + LAT; k++) begin
         if (k < 7) tick(mk(1'b1, vt[k].md, 1'b1, 1'b1, fill_i(vt[k].a), fill_i(vt[k].b)), 1'b1);
         else       tick(bub, 1'b1);
         ex = (k >= LAT) && (k - LAT < 7);
         chk("table_vout", int'(valid_out), int'(ex));
         if (ex) chk_mat("table_result", result, fill_o(vt[k-LAT].e));
      end

      // tiled accumulation: three MUL beats of ones -> 12, only the last emits
      for (int k = 0; k <= LAT + 3; k++) begin
         if (k < 3) tick(mk(1'b1, 2'd0, k == 0, k == 2, fill_i(8'd1), fill_i(8'd1)), 1'b1);
         else       tick(bub, 1'b1);
         if (k >= 1) chk("tile_vout", int'(valid_out), int'(k == LAT + 2));
         if (k == LAT + 2) chk_mat("tile_result", result, fill_o(32'd12));
      end

      // bubbles and stall: beat, 3 stalled cycles, bubble, beat
      for (int k = 0; k <= LAT + 6; k++) begin
         c = !(k >= 1 && k <= 3);
         if (k == 0)      tick(mk(1'b1, 2'd0, 1'b1, 1'b1, fill_i(8'd1), fill_i(8'd1)), c);
         else if (k == 5) tick(mk(1'b1, 2'd1, 1'b1, 1'b1, fill_i(8'd2), fill_i(8'd3)), c);
         else             tick(bub, c);
         if (k >= 1) chk("stall_vout", int'(valid_out), int'(k == LAT + 3 || k == LAT + 5));
         if (k >= 1 && k <= 3) chk_mat("stall_hold", result, fill_o(32'd12));
         if (k == LAT + 3 || k == LAT + 4) chk_mat("stall_res_a", result, fill_o(32'd4));
         if (k == LAT + 5) chk_mat("stall_res_b", result, fill_o(32'd5));
      end

      // wrap instance (N=2, 16-bit): 41 ADD beats of 127+127
      w_m1 = {(WN*WN){8'h7F}};
      w_m2 = {(WN*WN){8'h7F}};
      for (int k = 0; k <= 40 + WLAT; k++) begin
         w_valid = (k <= 40);
         w_first = (k == 0);
         w_last  = (k == 40);
         tick(mk(1'b0, 2'd1, 1'b0, 1'b0, '0, '0), 1'b1);
         chk("wrap_vout", int'(w_vout), int'(k == 40 + WLAT));
         if (k == 40 + WLAT)
            for (int i = 0; i < WN; i++)
               for (int j = 0; j < WN; j++)
                  chk("wrap_result", int'(w_res[i][j]), 10414);
      end
      w_valid = 1'b0; w_first = 1'b0; w_last = 1'b0;

      // async reset with beats in flight and an open accumulation
      for (int k = 0; k < 7; k++)
         tick(mk(1'b1, 2'd0, k == 0, k == 6, fill_i(8'd1), fill_i(8'd1)), 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("arst_vout", int'(valid_out), 0);
      chk_mat("arst_result", result, '0);
      model_clear();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 1; k <= LAT + 2; k++) begin
         tick(bub, 1'b1);
         chk("arst_stale", int'(valid_out), 0);
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) id[i][j] = (i == j) ? 8'd3 : 8'd0;
      tick(mk(1'b1, 2'd0, 1'b0, 1'b1, fill_i(8'd2), id), 1'b1);
      for (int k = 1; k <= LAT; k++) begin
         tick(bub, 1'b1);
         chk("arst_next_vout", int'(valid_out), int'(k == LAT));
         if (k == LAT) chk_mat("arst_next_result", result, fill_o(32'd6));
      end

      // randomized stream against the reference model
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               ra[i][j] = 8'($urandom);
               rb[i][j] = 8'($urandom);
            end
         tick(mk($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4, ra, rb),
              $urandom_range(0, 9) != 0);
         chk("rand_vout", int'(valid_out), int'(m_vout));
         chk_mat("rand_result", result, m_res);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
